// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported synchronous memory.
// Port 0 is a read-only fetch port; port 1 is a read/write data port.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_add,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
    logic              p0_ack_q, p0_ack_d;
    logic              p1_ack_q, p1_ack_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_add_q, mem_add_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic              busy_q, busy_d;

    // Next state plus next values of every registered output, derived from state_d.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        p0_ack_d   = 1'b0;
        p1_ack_d   = 1'b0;
        mem_rd_d   = 1'b0;
        mem_wr_d   = 1'b0;
        mem_add_d  = '0;
        mem_din_d  = '0;
        busy_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    // Contest goes to the port not granted last; a lone requester always wins.
                    gnt_d  = (p0_req && p1_req) ? !last_q : p1_req;
                    last_d = gnt_d;
                    if (gnt_d) begin
                        addr_d  = p1_addr;
                        we_d    = p1_we;
                        wdata_d = p1_wdata;
                    end else begin
                        addr_d  = p0_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = we_q ? ACK : WAIT;
            WAIT: begin
                if (gnt_q) begin
                    p1_rdata_d = mem_dout;
                end else begin
                    p0_rdata_d = mem_dout;
                end
                state_d = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        if (state_d == ISSUE) begin
            mem_rd_d  = !we_d;
            mem_wr_d  = we_d;
            mem_add_d = addr_d;
            mem_din_d = wdata_d;
        end
        if (state_d == ACK) begin
            p0_ack_d = !gnt_d;
            p1_ack_d = gnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
            p0_ack_q   <= 1'b0;
            p1_ack_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_add_q  <= '0;
            mem_din_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
            p0_ack_q   <= p0_ack_d;
            p1_ack_q   <= p1_ack_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            mem_add_q  <= mem_add_d;
            mem_din_q  <= mem_din_d;
            busy_q     <= busy_d;
        end
    end

    assign p0_ack   = p0_ack_q;
    assign p1_ack   = p1_ack_q;
    assign p0_rdata = p0_rdata_q;
    assign p1_rdata = p1_rdata_q;
    assign mem_rd   = mem_rd_q;
    assign mem_wr   = mem_wr_q;
    assign mem_add  = mem_add_q;
    assign mem_din  = mem_din_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous memory model attached.
module tb_mem_arbiter;

    logic       clk;
    logic       rst;
    logic       p0_req;
    logic [4:0] p0_addr;
    logic       p0_ack;
    logic [7:0] p0_rdata;
    logic       p1_req;
    logic       p1_we;
    logic [4:0] p1_addr;
    logic [7:0] p1_wdata;
    logic       p1_ack;
    logic [7:0] p1_rdata;
    logic       mem_rd;
    logic       mem_wr;
    logic [4:0] mem_add;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;
    logic       busy;

    logic [7:0] mem [32];
    logic       pre_we;
    logic [4:0] pre_addr;
    logic [7:0] pre_data;

    int checks;
    int failures;

    mem_arbiter #(.ADDR_W(5), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_add(mem_add), .mem_din(mem_din),
        .mem_dout(mem_dout), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: read data appears the cycle after mem_rd is sampled.
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (mem_wr) mem[mem_add] <= mem_din;
        if (mem_rd) mem_dout <= mem[mem_add];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [4:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        step();
        pre_we   = 1'b0;
    endtask

    task automatic test_reset();
        logic [33:0] v;
        rst = 1'b0;
        step();
        v = {p0_ack, p1_ack, mem_rd, mem_wr, busy, mem_add, mem_din, p0_rdata, p1_rdata};
        checks++;
        if (v !== 34'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", v);
        end
        #2 rst = 1'b1;
        step();
    endtask

    task automatic test_read_p0();
        p0_addr = 5'd3;
        p0_req  = 1'b1;
        step();
        checks++;
        if ({mem_rd, mem_wr, mem_add, busy} !== {1'b1, 1'b0, 5'd3, 1'b1}) begin
            failures++;
            $display("FAIL read_issue got=%b exp=%b", {mem_rd, mem_wr, mem_add, busy}, {1'b1, 1'b0, 5'd3, 1'b1});
        end
        step();
        checks++;
        if ({mem_rd, mem_add, p0_ack, busy} !== {1'b0, 5'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL read_wait got=%b exp=%b", {mem_rd, mem_add, p0_ack, busy}, {1'b0, 5'd0, 1'b0, 1'b1});
        end
        step();
        checks++;
        if ({p0_ack, p1_ack, p0_rdata} !== {1'b1, 1'b0, 8'h5A}) begin
            failures++;
            $display("FAIL read_ack got=%h exp=%h", {p0_ack, p1_ack, p0_rdata}, {1'b1, 1'b0, 8'h5A});
        end
        p0_req = 1'b0;
        step();
        checks++;
        if ({p0_ack, busy} !== 2'b00) begin
            failures++;
            $display("FAIL read_done got=%b exp=00", {p0_ack, busy});
        end
    endtask

    task automatic test_write_p1();
        p1_we    = 1'b1;
        p1_addr  = 5'd7;
        p1_wdata = 8'hC3;
        p1_req   = 1'b1;
        step();
        checks++;
        if ({mem_wr, mem_rd, mem_add, mem_din} !== {1'b1, 1'b0, 5'd7, 8'hC3}) begin
            failures++;
            $display("FAIL write_issue got=%h exp=%h", {mem_wr, mem_rd, mem_add, mem_din}, {1'b1, 1'b0, 5'd7, 8'hC3});
        end
        p1_wdata = 8'h00;
        step();
        checks++;
        if ({p1_ack, p0_ack, mem_wr, p0_rdata, p1_rdata} !== {1'b1, 1'b0, 1'b0, 8'h5A, 8'h00}) begin
            failures++;
            $display("FAIL write_ack got=%h exp=%h", {p1_ack, p0_ack, mem_wr, p0_rdata, p1_rdata}, {1'b1, 1'b0, 1'b0, 8'h5A, 8'h00});
        end
        p1_req = 1'b0;
        p1_we  = 1'b0;
        step();
        p1_req = 1'b1;
        step();
        step();
        step();
        checks++;
        if ({p1_ack, p1_rdata} !== {1'b1, 8'hC3}) begin
            failures++;
            $display("FAIL write_readback got=%h exp=%h", {p1_ack, p1_rdata}, {1'b1, 8'hC3});
        end
        p1_req = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_acks;
        rst = 1'b0;
        step();
        #2 rst = 1'b1;
        p0_addr = 5'd3;
        p1_addr = 5'd7;
        p1_we   = 1'b0;
        p0_req  = 1'b1;
        p1_req  = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i % 4 == 3) exp_acks = ((i / 4) % 2 == 1) ? 2'b01 : 2'b10;
            else            exp_acks = 2'b00;
            checks++;
            if ({p0_ack, p1_ack} !== exp_acks) begin
                failures++;
                $display("FAIL rr_acks cycle=%0d got=%b exp=%b", i, {p0_ack, p1_ack}, exp_acks);
            end
        end
        checks++;
        if ({p0_rdata, p1_rdata} !== {8'h5A, 8'hC3}) begin
            failures++;
            $display("FAIL rr_rdata got=%h exp=5ac3", {p0_rdata, p1_rdata});
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        step();
    endtask

    task automatic test_addr_change();
        p1_addr = 5'd12;
        p1_req  = 1'b1;
        step();
        p0_req  = 1'b1;
        p0_addr = 5'd20;
        step();
        p0_addr = 5'd21;
        step();
        checks++;
        if ({p1_ack, p0_ack, p1_rdata, p0_rdata} !== {1'b1, 1'b0, 8'h3C, 8'h5A}) begin
            failures++;
            $display("FAIL ac_p1_ack got=%h exp=%h", {p1_ack, p0_ack, p1_rdata, p0_rdata}, {1'b1, 1'b0, 8'h3C, 8'h5A});
        end
        p1_req  = 1'b0;
        p0_addr = 5'd22;
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL ac_idle busy got=%b exp=0", busy);
        end
        p0_addr = 5'd7;
        step();
        checks++;
        if ({mem_rd, mem_add} !== {1'b1, 5'd7}) begin
            failures++;
            $display("FAIL ac_p0_issue got=%b exp=%b", {mem_rd, mem_add}, {1'b1, 5'd7});
        end
        p0_addr = 5'd0;
        step();
        step();
        checks++;
        if ({p0_ack, p0_rdata, p1_rdata} !== {1'b1, 8'hC3, 8'h3C}) begin
            failures++;
            $display("FAIL ac_p0_ack got=%h exp=%h", {p0_ack, p0_rdata, p1_rdata}, {1'b1, 8'hC3, 8'h3C});
        end
        p0_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        logic [33:0] v;
        p1_we    = 1'b1;
        p1_addr  = 5'd9;
        p1_wdata = 8'hEE;
        p1_req   = 1'b1;
        step();
        checks++;
        if ({mem_wr, mem_add} !== {1'b1, 5'd9}) begin
            failures++;
            $display("FAIL rm_issue got=%b exp=%b", {mem_wr, mem_add}, {1'b1, 5'd9});
        end
        #1 rst = 1'b0;
        #1;
        v = {p0_ack, p1_ack, mem_rd, mem_wr, busy, mem_add, mem_din, p0_rdata, p1_rdata};
        checks++;
        if (v !== 34'd0) begin
            failures++;
            $display("FAIL rm_async_reset got=%h exp=0", v);
        end
        p1_req = 1'b0;
        p1_we  = 1'b0;
        step();
        #2 rst = 1'b1;
        step();
        step();
        checks++;
        if ({p1_ack, busy, mem[9]} !== {1'b0, 1'b0, 8'h11}) begin
            failures++;
            $display("FAIL rm_aftermath got=%h exp=%h", {p1_ack, busy, mem[9]}, {1'b0, 1'b0, 8'h11});
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_acks;
        p1_we    = 1'b1;
        p1_addr  = 5'd1;
        p1_wdata = 8'h77;
        p1_req   = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            exp_acks = (i % 3 == 2) ? 2'b01 : 2'b00;
            checks++;
            if ({p0_ack, p1_ack} !== exp_acks) begin
                failures++;
                $display("FAIL b2b_acks cycle=%0d got=%b exp=%b", i, {p0_ack, p1_ack}, exp_acks);
            end
        end
        p1_req = 1'b0;
        p1_we  = 1'b0;
        step();
        checks++;
        if ({mem[1], p1_rdata, busy} !== {8'h77, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL b2b_final got=%h exp=%h", {mem[1], p1_rdata, busy}, {8'h77, 8'h00, 1'b0});
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        p0_req   = 1'b0;
        p0_addr  = '0;
        p1_req   = 1'b0;
        p1_we    = 1'b0;
        p1_addr  = '0;
        p1_wdata = '0;
        pre_we   = 1'b0;
        pre_addr = '0;
        pre_data = '0;

        test_reset();
        preload(5'd3, 8'h5A);
        preload(5'd12, 8'h3C);
        preload(5'd9, 8'h11);
        test_read_p0();
        test_write_p1();
        test_round_robin();
        test_addr_change();
        test_reset_mid();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
